// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative cache data store.
package cache_pkg;

    typedef enum logic [0:0] {
        FILL_IDLE,
        FILL_BUSY
    } fill_state_e;

    localparam int unsigned DEF_BLOCK_SIZE = 256;
    localparam int unsigned DEF_SETS_LOG2  = 3;
    localparam int unsigned DEF_WAYS       = 2;
    localparam int unsigned DEF_BEAT_WIDTH = 64;

    // Index width for n entries, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned beats_per_line(input int unsigned block_size,
                                                   input int unsigned beat_width);
        return block_size / beat_width;
    endfunction

    function automatic int unsigned bytes_per_line(input int unsigned block_size);
        return block_size / 8;
    endfunction

    localparam int unsigned DEF_BEATS = beats_per_line(DEF_BLOCK_SIZE, DEF_BEAT_WIDTH);
    localparam int unsigned DEF_BYTES = bytes_per_line(DEF_BLOCK_SIZE);
    localparam int unsigned DEF_WAY_W = idx_width(DEF_WAYS);
    localparam int unsigned DEF_CNT_W = idx_width(DEF_BEATS);

endpackage

// File: rtl/cache_line_fill.sv
// Beat-serial line-fill engine: assembles memory beats into a line buffer and
// presents the completed line for a single-cycle atomic commit.
module cache_line_fill
    import cache_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int unsigned SETS_LOG2  = DEF_SETS_LOG2,
    parameter int unsigned WAYS       = DEF_WAYS,
    parameter int unsigned BEAT_WIDTH = DEF_BEAT_WIDTH,
    localparam int unsigned WAY_W     = idx_width(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fill_start,
    input  logic [SETS_LOG2-1:0]  fill_set,
    input  logic [WAY_W-1:0]      fill_way,
    input  logic                  fill_beat_valid,
    input  logic [BEAT_WIDTH-1:0] fill_beat_data,
    output logic                  fill_busy,
    output logic                  fill_done,
    output logic                  commit_en,
    output logic [SETS_LOG2-1:0]  commit_set,
    output logic [WAY_W-1:0]      commit_way,
    output logic [BLOCK_SIZE-1:0] commit_line
);

    localparam int unsigned BEATS = beats_per_line(BLOCK_SIZE, BEAT_WIDTH);
    localparam int unsigned CNT_W = idx_width(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    fill_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SETS_LOG2-1:0]  set_q, set_d;
    logic [WAY_W-1:0]      way_q, way_d;
    logic [BLOCK_SIZE-1:0] buf_q, buf_d;
    logic                  done_q, done_d;
    logic [BLOCK_SIZE-1:0] line_with_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL_IDLE;
            cnt_q   <= '0;
            set_q   <= '0;
            way_q   <= '0;
            buf_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            set_q   <= set_d;
            way_q   <= way_d;
            buf_q   <= buf_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        set_d     = set_q;
        way_d     = way_q;
        buf_d     = buf_q;
        done_d    = 1'b0;
        commit_en = 1'b0;

        // Committed line is the buffer with the current beat already merged in.
        line_with_beat = buf_q;
        line_with_beat[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] = fill_beat_data;

        unique case (state_q)
            FILL_IDLE: begin
                if (fill_start) begin
                    state_d = FILL_BUSY;
                    cnt_d   = '0;
                    set_d   = fill_set;
                    way_d   = fill_way;
                end
            end
            FILL_BUSY: begin
                if (fill_beat_valid) begin
                    buf_d = line_with_beat;
                    if (cnt_q == LAST_BEAT) begin
                        commit_en = 1'b1;
                        state_d   = FILL_IDLE;
                        cnt_d     = '0;
                        done_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = FILL_IDLE;
        endcase
    end

    assign fill_busy   = (state_q == FILL_BUSY);
    assign fill_done   = done_q;
    assign commit_set  = set_q;
    assign commit_way  = way_q;
    assign commit_line = line_with_beat;

endmodule

// File: rtl/cache_data_array.sv
// Set-associative cache data store: byte-enabled CPU writes, atomic line-fill
// commits and a registered write-first read port.
module cache_data_array
    import cache_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int unsigned SETS_LOG2  = DEF_SETS_LOG2,
    parameter int unsigned WAYS       = DEF_WAYS,
    parameter int unsigned BEAT_WIDTH = DEF_BEAT_WIDTH,
    localparam int unsigned WAY_W     = idx_width(WAYS),
    localparam int unsigned BYTES     = bytes_per_line(BLOCK_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [SETS_LOG2-1:0]  rd_set,
    input  logic [WAY_W-1:0]      rd_way,
    output logic [BLOCK_SIZE-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  wr_en,
    input  logic [SETS_LOG2-1:0]  wr_set,
    input  logic [WAY_W-1:0]      wr_way,
    input  logic [BYTES-1:0]      wr_be,
    input  logic [BLOCK_SIZE-1:0] wr_data,
    input  logic                  fill_start,
    input  logic [SETS_LOG2-1:0]  fill_set,
    input  logic [WAY_W-1:0]      fill_way,
    input  logic                  fill_beat_valid,
    input  logic [BEAT_WIDTH-1:0] fill_beat_data,
    output logic                  fill_busy,
    output logic                  fill_done
);

    localparam int unsigned SETS = 2 ** SETS_LOG2;
    localparam bit SINGLE_WAY = (WAYS == 1);

    logic [BLOCK_SIZE-1:0] mem_q [WAYS][SETS];
    logic [BLOCK_SIZE-1:0] mem_d [WAYS][SETS];
    logic [BLOCK_SIZE-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    logic                  commit_en;
    logic [SETS_LOG2-1:0]  commit_set;
    logic [WAY_W-1:0]      commit_way;
    logic [BLOCK_SIZE-1:0] commit_line;

    logic [WAY_W-1:0]      wr_way_eff, rd_way_eff, commit_way_eff;

    cache_line_fill #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .SETS_LOG2  (SETS_LOG2),
        .WAYS       (WAYS),
        .BEAT_WIDTH (BEAT_WIDTH)
    ) u_fill (
        .clk             (clk),
        .rst             (rst),
        .fill_start      (fill_start),
        .fill_set        (fill_set),
        .fill_way        (fill_way),
        .fill_beat_valid (fill_beat_valid),
        .fill_beat_data  (fill_beat_data),
        .fill_busy       (fill_busy),
        .fill_done       (fill_done),
        .commit_en       (commit_en),
        .commit_set      (commit_set),
        .commit_way      (commit_way),
        .commit_line     (commit_line)
    );

    // A direct-mapped array ignores the way inputs entirely.
    assign wr_way_eff     = SINGLE_WAY ? '0 : wr_way;
    assign rd_way_eff     = SINGLE_WAY ? '0 : rd_way;
    assign commit_way_eff = SINGLE_WAY ? '0 : commit_way;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                for (int unsigned s = 0; s < SETS; s++) begin
                    mem_q[w][s] <= '0;
                end
            end
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Fill commit lands first so a same-cycle CPU store overrides its bytes;
    // the read then samples the fully updated array (write-first).
    always_comb begin
        mem_d = mem_q;
        if (commit_en) begin
            mem_d[commit_way_eff][commit_set] = commit_line;
        end
        if (wr_en) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (wr_be[b]) begin
                    mem_d[wr_way_eff][wr_set][b*8 +: 8] = wr_data[b*8 +: 8];
                end
            end
        end
        rd_valid_d = rd_en;
        rd_data_d  = rd_en ? mem_d[rd_way_eff][rd_set] : rd_data_q;
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_cache_data_array.sv
// Directed self-checking bench for cache_data_array (default parameters).
module tb_cache_data_array;

    localparam int unsigned BLOCK_SIZE = 256;
    localparam int unsigned SETS_LOG2  = 3;
    localparam int unsigned WAYS       = 2;
    localparam int unsigned BEAT_WIDTH = 64;
    localparam int unsigned BYTES      = BLOCK_SIZE / 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  rd_en;
    logic [SETS_LOG2-1:0]  rd_set;
    logic [0:0]            rd_way;
    logic [BLOCK_SIZE-1:0] rd_data;
    logic                  rd_valid;
    logic                  wr_en;
    logic [SETS_LOG2-1:0]  wr_set;
    logic [0:0]            wr_way;
    logic [BYTES-1:0]      wr_be;
    logic [BLOCK_SIZE-1:0] wr_data;
    logic                  fill_start;
    logic [SETS_LOG2-1:0]  fill_set;
    logic [0:0]            fill_way;
    logic                  fill_beat_valid;
    logic [BEAT_WIDTH-1:0] fill_beat_data;
    logic                  fill_busy;
    logic                  fill_done;

    int n_tests = 0;
    int n_fail  = 0;

    cache_data_array #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .SETS_LOG2  (SETS_LOG2),
        .WAYS       (WAYS),
        .BEAT_WIDTH (BEAT_WIDTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rd_en           (rd_en),
        .rd_set          (rd_set),
        .rd_way          (rd_way),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .wr_en           (wr_en),
        .wr_set          (wr_set),
        .wr_way          (wr_way),
        .wr_be           (wr_be),
        .wr_data         (wr_data),
        .fill_start      (fill_start),
        .fill_set        (fill_set),
        .fill_way        (fill_way),
        .fill_beat_valid (fill_beat_valid),
        .fill_beat_data  (fill_beat_data),
        .fill_busy       (fill_busy),
        .fill_done       (fill_done)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BEAT_WIDTH-1:0] beat_of(input logic [7:0] b);
        return {8{b}};
    endfunction

    function automatic logic [BLOCK_SIZE-1:0] line4(input logic [7:0] b0, input logic [7:0] b1,
                                                    input logic [7:0] b2, input logic [7:0] b3);
        return {beat_of(b3), beat_of(b2), beat_of(b1), beat_of(b0)};
    endfunction

    task automatic idle_inputs();
        rd_en = 1'b0; rd_set = '0; rd_way = '0;
        wr_en = 1'b0; wr_set = '0; wr_way = '0; wr_be = '0; wr_data = '0;
        fill_start = 1'b0; fill_set = '0; fill_way = '0;
        fill_beat_valid = 1'b0; fill_beat_data = '0;
    endtask

    task automatic do_read(input logic [SETS_LOG2-1:0] s, input logic [0:0] w,
                           output logic [BLOCK_SIZE-1:0] data, output logic valid);
        rd_en = 1'b1; rd_set = s; rd_way = w;
        tick();
        data  = rd_data;
        valid = rd_valid;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [BLOCK_SIZE-1:0] d;
        logic v;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        n_tests++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        n_tests++; if (fill_busy !== 1'b0) begin n_fail++; $display("FAIL reset_fill_busy got=%b exp=0", fill_busy); end
        n_tests++; if (fill_done !== 1'b0) begin n_fail++; $display("FAIL reset_fill_done got=%b exp=0", fill_done); end
        rst = 1'b0;
        do_read(3'd5, 1'b1, d, v);
        n_tests++; if (v !== 1'b1) begin n_fail++; $display("FAIL reset_read_valid got=%b exp=1", v); end
        n_tests++; if (d !== '0) begin n_fail++; $display("FAIL reset_read_data got=%h exp=0", d); end
        tick();
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL idle_rd_valid got=%b exp=0", rd_valid); end
    endtask

    task automatic test_byte_write();
        logic [BLOCK_SIZE-1:0] d, exp;
        logic v;
        wr_en = 1'b1; wr_set = 3'd2; wr_way = 1'b0; wr_be = '1; wr_data = {32{8'hA5}};
        tick();
        wr_be = 32'h0000_0001; wr_data = {32{8'hFF}};
        tick();
        wr_be = '0; wr_data = {32{8'h3C}};
        tick();
        wr_en = 1'b0;
        exp = {{31{8'hA5}}, 8'hFF};
        do_read(3'd2, 1'b0, d, v);
        n_tests++; if (d !== exp) begin n_fail++; $display("FAIL byte_merge got=%h exp=%h", d, exp); end
        tick();
        n_tests++; if (rd_data !== exp) begin n_fail++; $display("FAIL rd_data_hold got=%h exp=%h", rd_data, exp); end
        do_read(3'd2, 1'b1, d, v);
        n_tests++; if (d !== '0) begin n_fail++; $display("FAIL other_way_untouched got=%h exp=0", d); end
    endtask

    task automatic test_forward();
        rd_en = 1'b1; rd_set = 3'd3; rd_way = 1'b1;
        wr_en = 1'b1; wr_set = 3'd3; wr_way = 1'b1; wr_be = '1; wr_data = 256'h1234;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        n_tests++; if (rd_data !== 256'h1234) begin n_fail++; $display("FAIL forward_data got=%h exp=%h", rd_data, 256'h1234); end
        n_tests++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL forward_valid got=%b exp=1", rd_valid); end
    endtask

    task automatic test_fill();
        logic [BLOCK_SIZE-1:0] d, exp;
        logic v;
        int dones = 0;
        fill_beat_valid = 1'b1; fill_beat_data = beat_of(8'hDD);
        tick();
        fill_beat_valid = 1'b0;
        n_tests++; if (fill_busy !== 1'b0) begin n_fail++; $display("FAIL idle_beat_busy got=%b exp=0", fill_busy); end
        fill_start = 1'b1; fill_set = 3'd7; fill_way = 1'b1;
        tick();
        fill_start = 1'b0;
        n_tests++; if (fill_busy !== 1'b1) begin n_fail++; $display("FAIL fill_busy_start got=%b exp=1", fill_busy); end
        fill_beat_valid = 1'b1; fill_beat_data = beat_of(8'h11);
        tick();
        if (fill_done === 1'b1) dones++;
        fill_beat_data = beat_of(8'h22);
        fill_start = 1'b1; fill_set = 3'd0; fill_way = 1'b0;
        tick();
        if (fill_done === 1'b1) dones++;
        fill_start = 1'b0; fill_beat_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (fill_done === 1'b1) dones++;
        end
        fill_beat_valid = 1'b1; fill_beat_data = beat_of(8'h33);
        tick();
        if (fill_done === 1'b1) dones++;
        n_tests++; if (fill_busy !== 1'b1) begin n_fail++; $display("FAIL busy_before_last got=%b exp=1", fill_busy); end
        fill_beat_data = beat_of(8'h44);
        tick();
        fill_beat_valid = 1'b0;
        n_tests++; if (fill_done !== 1'b1) begin n_fail++; $display("FAIL fill_done_pulse got=%b exp=1", fill_done); end
        n_tests++; if (fill_busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_commit got=%b exp=0", fill_busy); end
        tick();
        n_tests++; if (fill_done !== 1'b0) begin n_fail++; $display("FAIL fill_done_width got=%b exp=0", fill_done); end
        n_tests++; if (dones !== 0) begin n_fail++; $display("FAIL early_done got=%0d exp=0", dones); end
        n_tests++; if (fill_busy !== 1'b0) begin n_fail++; $display("FAIL midfill_start_ignored got=%b exp=0", fill_busy); end
        exp = line4(8'h11, 8'h22, 8'h33, 8'h44);
        do_read(3'd7, 1'b1, d, v);
        n_tests++; if (d !== exp) begin n_fail++; $display("FAIL fill_line got=%h exp=%h", d, exp); end
        do_read(3'd0, 1'b0, d, v);
        n_tests++; if (d !== '0) begin n_fail++; $display("FAIL midfill_target_untouched got=%h exp=0", d); end
    endtask

    task automatic test_fill_write_collide();
        logic [BLOCK_SIZE-1:0] d, exp;
        logic v;
        fill_start = 1'b1; fill_set = 3'd4; fill_way = 1'b0;
        tick();
        fill_start = 1'b0;
        fill_beat_valid = 1'b1; fill_beat_data = beat_of(8'h55); tick();
        fill_beat_data = beat_of(8'h66); tick();
        fill_beat_data = beat_of(8'h77); tick();
        fill_beat_data = beat_of(8'h88);
        wr_en = 1'b1; wr_set = 3'd4; wr_way = 1'b0; wr_be = 32'h0000_0001; wr_data = {32{8'hEE}};
        tick();
        fill_beat_valid = 1'b0; wr_en = 1'b0; wr_be = '0;
        n_tests++; if (fill_done !== 1'b1) begin n_fail++; $display("FAIL collide_done got=%b exp=1", fill_done); end
        exp = line4(8'h55, 8'h66, 8'h77, 8'h88);
        exp[7:0] = 8'hEE;
        do_read(3'd4, 1'b0, d, v);
        n_tests++; if (d !== exp) begin n_fail++; $display("FAIL collide_line got=%h exp=%h", d, exp); end
    endtask

    task automatic test_back_to_back();
        logic [BLOCK_SIZE-1:0] d, exp;
        logic v;
        int dones = 0;
        fill_start = 1'b1; fill_set = 3'd6; fill_way = 1'b0;
        tick();
        fill_start = 1'b0;
        fill_beat_valid = 1'b1; fill_beat_data = beat_of(8'hAB); tick();
        fill_beat_data = beat_of(8'hCD); tick();
        fill_beat_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (fill_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", fill_busy); end
        n_tests++; if (fill_done !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b exp=0", fill_done); end
        tick();
        n_tests++; if (fill_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_late_done got=%b exp=0", fill_done); end
        do_read(3'd6, 1'b0, d, v);
        n_tests++; if (d !== '0) begin n_fail++; $display("FAIL abort_line got=%h exp=0", d); end
        do_read(3'd7, 1'b1, d, v);
        n_tests++; if (d !== '0) begin n_fail++; $display("FAIL reset_clears_lines got=%h exp=0", d); end
        // Second fill starts in the cycle right after the first commit.
        fill_start = 1'b1; fill_set = 3'd6; fill_way = 1'b0;
        tick();
        fill_start = 1'b0;
        fill_beat_valid = 1'b1;
        fill_beat_data = beat_of(8'h99); tick();
        fill_beat_data = beat_of(8'hAA); tick();
        fill_beat_data = beat_of(8'hBB); tick();
        fill_beat_data = beat_of(8'hCC);
        tick();
        if (fill_done === 1'b1) dones++;
        fill_beat_valid = 1'b0;
        fill_start = 1'b1; fill_set = 3'd1; fill_way = 1'b1;
        tick();
        fill_start = 1'b0;
        n_tests++; if (fill_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got=%b exp=1", fill_busy); end
        fill_beat_valid = 1'b1;
        fill_beat_data = beat_of(8'h01); tick();
        fill_beat_data = beat_of(8'h02); tick();
        fill_beat_data = beat_of(8'h03); tick();
        fill_beat_data = beat_of(8'h04);
        tick();
        if (fill_done === 1'b1) dones++;
        fill_beat_valid = 1'b0;
        n_tests++; if (dones !== 2) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=2", dones); end
        exp = line4(8'h99, 8'hAA, 8'hBB, 8'hCC);
        do_read(3'd6, 1'b0, d, v);
        n_tests++; if (d !== exp) begin n_fail++; $display("FAIL refill_line got=%h exp=%h", d, exp); end
        exp = line4(8'h01, 8'h02, 8'h03, 8'h04);
        do_read(3'd1, 1'b1, d, v);
        n_tests++; if (d !== exp) begin n_fail++; $display("FAIL b2b_line got=%h exp=%h", d, exp); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_byte_write();
        test_forward();
        test_fill();
        test_fill_write_collide();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
